// File: rtl/gpu_bg_pkg.sv
// Shared types and constants for the scrolling background layer.
// Optional scroll logic is enabled with GPU_BG_SCROLL_EN.
package gpu_bg_pkg;

  typedef struct packed {
    logic       csel;
    logic       hflip;
    logic       vflip;
    logic [4:0] pattern;
  } tile_attr_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] x;
    logic [2:0] y;
  } bg_s1_t;

  typedef struct packed {
    logic       valid;
    logic       csel;
    logic [2:0] col;
  } bg_s2_t;

  localparam int OFS_COLORS   = 960;
  localparam int OFS_SCROLL_X = 961;
  localparam int OFS_SCROLL_Y = 962;
  localparam int OFS_BANK     = 963;
  localparam int BG_LATENCY   = 3;
  localparam int BG_SCREEN_H  = 240;

endpackage

// File: rtl/bg_byte_ram.sv
// Simple dual-port byte RAM, registered read-first read port.
// Maps onto inferable synchronous block RAM; contents are not reset.
module bg_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/scroll_background_m.sv
// Pipelined 32x30 tile background renderer, 3-cycle latency.
// Fine scrolling and frame latch are built when GPU_BG_SCROLL_EN is defined.
module scroll_background_m
  import gpu_bg_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int PMB_BASE        = 'h200,
  parameter int NTBL_BASE       = 'h400,
  parameter int PMB_BANKS       = 1
) (
  input  logic                       clk_12_5875,
  input  logic                       rst_n,
  input  logic [7:0]                 current_x,
  input  logic [7:0]                 current_y,
  input  logic                       pixel_valid_in,
  input  logic                       writable,
  input  logic [7:0]                 data_in,
  input  logic [VRAM_ADDR_WIDTH-1:0] address,
  input  logic                       write_enable,
  output logic [1:0]                 r,
  output logic [1:0]                 g,
  output logic [1:0]                 b,
  output logic                       pixel_valid_out
);

  localparam int AW        = VRAM_ADDR_WIDTH;
  localparam int PMB_SIZE  = 512 * PMB_BANKS;
  localparam int NTBL_SIZE = 1024;
  localparam int BW   = (PMB_BANKS > 1) ? $clog2(PMB_BANKS) : 1;
  localparam int PWAW = $clog2(PMB_BANKS) + 8;
  localparam int PBAW = PWAW + 1;

  generate
    if ((PMB_BASE < NTBL_BASE + NTBL_SIZE) &&
        (NTBL_BASE < PMB_BASE + PMB_SIZE)) begin : g_overlap
      $error("PMB and NTBL windows overlap");
    end
  endgenerate

  logic            wr_ok, in_pmb, in_ntbl, sh_we;
  logic [PBAW-1:0] pmb_ofs;
  logic [9:0]      ntbl_ofs;

  assign wr_ok   = write_enable && writable;
  assign in_pmb  = 32'(address) >= PMB_BASE &&
                   32'(address) < PMB_BASE + PMB_SIZE;
  assign in_ntbl = 32'(address) >= NTBL_BASE &&
                   32'(address) < NTBL_BASE + NTBL_SIZE;
  assign pmb_ofs  = PBAW'(address - AW'(PMB_BASE));
  assign ntbl_ofs = 10'(address - AW'(NTBL_BASE));
  assign sh_we    = wr_ok && in_ntbl;

  logic       fs;
  logic [5:0] colors;
  logic [7:0] eff_x, eff_y;

  assign fs = pixel_valid_in && current_x == 8'd0 && current_y == 8'd0;

  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) colors <= '0;
    else if (sh_we && ntbl_ofs == 10'(OFS_COLORS)) colors <= data_in[5:0];
  end

`ifdef GPU_BG_SCROLL_EN
  logic [7:0] scroll_x_pend, scroll_y_pend;
  logic [7:0] scroll_x_act, scroll_y_act;
  logic [7:0] sx, sy;
  logic [8:0] sum_y;

  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_pend <= '0;
      scroll_y_pend <= '0;
      scroll_x_act  <= '0;
      scroll_y_act  <= '0;
    end else begin
      if (sh_we && ntbl_ofs == 10'(OFS_SCROLL_X)) scroll_x_pend <= data_in;
      if (sh_we && ntbl_ofs == 10'(OFS_SCROLL_Y)) scroll_y_pend <= data_in;
      if (fs) begin
        scroll_x_act <= scroll_x_pend;
        scroll_y_act <= scroll_y_pend;
      end
    end
  end

  // the frame-start pixel sees pend before act has loaded it
  assign sx    = fs ? scroll_x_pend : scroll_x_act;
  assign sy    = fs ? scroll_y_pend : scroll_y_act;
  assign eff_x = current_x + sx;
  assign sum_y = {1'b0, current_y} + {1'b0, sy};
  assign eff_y = (sum_y >= 9'(BG_SCREEN_H)) ?
                 8'(sum_y - 9'(BG_SCREEN_H)) : sum_y[7:0];
`else
  assign eff_x = current_x;
  assign eff_y = current_y;
`endif

  logic [BW-1:0] bank_pend, bank_act, bank_sel;

  generate
    if (PMB_BANKS > 1) begin : g_bank
      always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
          bank_pend <= '0;
          bank_act  <= '0;
        end else begin
          if (sh_we && ntbl_ofs == 10'(OFS_BANK))
            bank_pend <= data_in[BW-1:0];
          if (fs) bank_act <= bank_pend;
        end
      end
    end else begin : g_nobank
      assign bank_pend = '0;
      assign bank_act  = '0;
    end
  endgenerate

  assign bank_sel = fs ? bank_pend : bank_act;

  logic [7:0]      ntbl_q, pmb_e_q, pmb_o_q;
  logic [9:0]      ntbl_raddr;
  logic [PWAW-1:0] pmb_raddr;

  assign ntbl_raddr = {eff_y[7:3], eff_x[7:3]};

  bg_byte_ram #(.DEPTH(NTBL_SIZE)) u_ntbl (
    .clk   (clk_12_5875),
    .we    (wr_ok && in_ntbl),
    .waddr (ntbl_ofs),
    .wdata (data_in),
    .raddr (ntbl_raddr),
    .rdata (ntbl_q)
  );

  bg_byte_ram #(.DEPTH(PMB_SIZE / 2)) u_pmb_e (
    .clk   (clk_12_5875),
    .we    (wr_ok && in_pmb && !pmb_ofs[0]),
    .waddr (pmb_ofs[PBAW-1:1]),
    .wdata (data_in),
    .raddr (pmb_raddr),
    .rdata (pmb_e_q)
  );

  bg_byte_ram #(.DEPTH(PMB_SIZE / 2)) u_pmb_o (
    .clk   (clk_12_5875),
    .we    (wr_ok && in_pmb && pmb_ofs[0]),
    .waddr (pmb_ofs[PBAW-1:1]),
    .wdata (data_in),
    .raddr (pmb_raddr),
    .rdata (pmb_o_q)
  );

  bg_s1_t        s1;
  bg_s2_t        s2;
  logic [BW-1:0] s1_bank;
  tile_attr_t    attr;
  logic [2:0]    row, col;
  logic [15:0]   line;
  logic [1:0]    pix;
  logic [2:0]    colour;

  assign attr      = tile_attr_t'(ntbl_q);
  assign row       = attr.vflip ? ~s1.y : s1.y;
  assign col       = attr.hflip ? ~s1.x : s1.x;
  assign pmb_raddr = PWAW'({s1_bank, attr.pattern, row});
  assign line      = {pmb_e_q, pmb_o_q};
  assign pix       = line[{~s2.col, 1'b0} +: 2];
  assign colour    = s2.csel ? colors[5:3] : colors[2:0];

  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      s1              <= '0;
      s1_bank         <= '0;
      s2              <= '0;
      r               <= '0;
      g               <= '0;
      b               <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      s1.valid        <= pixel_valid_in;
      s1.x            <= eff_x[2:0];
      s1.y            <= eff_y[2:0];
      s1_bank         <= bank_sel;
      s2.valid        <= s1.valid;
      s2.csel         <= attr.csel;
      s2.col          <= col;
      r               <= s2.valid ? pix & {2{colour[2]}} : 2'b00;
      g               <= s2.valid ? pix & {2{colour[1]}} : 2'b00;
      b               <= s2.valid ? pix & {2{colour[0]}} : 2'b00;
      pixel_valid_out <= s2.valid;
    end
  end

endmodule

// File: doc/scroll_background_m.md
# scroll_background_m

Parametrised, pipelined background-layer renderer for the GPU. It renders a 32×30 nametable of 8×8, 2-bpp tiles to 2-bit-per-channel RGB. It adds several features:
- per-frame-latched fine X/Y scrolling with vertical wrap at 240 lines;
- selectable pattern banks;
- a fixed 3-cycle pipeline built on synchronous, inferable block RAM.

All writes come from the pixel-clock domain. The block sits between the video timing generator and the layer mixer.

## Interface
- `VRAM_ADDR_WIDTH`, default 12: width of `address`.
- `PMB_BASE`, default 12'h200: first pattern-memory byte address.
- `NTBL_BASE`, default 12'h400: first nametable byte address; the nametable spans 1024 bytes.
- `PMB_BANKS`, default 1: number of 32-pattern banks (1, 2 or 4); the PMB spans 512×`PMB_BANKS` bytes.

Ports:
- `clk_12_5875`  in  1: pixel clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `current_x`, `current_y`  in  8 each: screen pixel coordinate.
- `pixel_valid_in`  in  1: the coordinate is in the visible area.
- `writable`  in  1: VRAM writes permitted (vblank).
- `data_in`  in  8: write data.
- `address`  in  `VRAM_ADDR_WIDTH`: write address.
- `write_enable`  in  1: write strobe, sampled on the rising edge of `clk_12_5875`.
- `r`, `g`, `b`  out  2 each: pixel colour.
- `pixel_valid_out`  out  1: `pixel_valid_in` delayed by 3 cycles.

## Operation
Writes:
- A write is accepted when `write_enable && writable`; it is otherwise dropped.
- PMB window: written to PMB RAM at offset `address-PMB_BASE`. Even offsets go to the even bank, odd offsets to the odd bank.
- NTBL window: written to NTBL RAM at offset `address-NTBL_BASE`.
- Shadow registers are also updated on NTBL writes at these offsets:
  - 960 → `colors` (colour0 = [2:0], colour1 = [5:3]).
  - 961 → `scroll_x_pend`.
  - 962 → `scroll_y_pend`.
  - 963 → `bank_pend` (low `$clog2(PMB_BANKS)` bits; no register when `PMB_BANKS`=1).
- Addresses outside both windows are ignored.

Frame latch:
- Frame start is `pixel_valid_in && current_x==0 && current_y==0`.
- At frame start, `scroll_*_act` and `bank_act` load their `_pend` values.
- The (0,0) pixel itself uses the pend values, via a bypass.
- `colors` takes effect immediately and is not frame-latched.

Coordinate mapping (stage 0):
- `eff_x = (current_x + scroll_x) mod 256`, 8-bit wrap.
- `sum_y = current_y + scroll_y` is a 9-bit sum; `eff_y = sum_y >= 240 ? sum_y-240 : sum_y`.
- `current_y` ≥ 240 is out of contract; the output is don't-care but `pixel_valid_out` still tracks its input.

Tile decode:
- NTBL index is `{eff_y[7:3], eff_x[7:3]}`.
- Tile byte fields: [7] colour select, [6] hflip, [5] vflip, [4:0] pattern.
- PMB word index is `{bank_act, pattern, row}`, where row = vflip ? 7−y[2:0] : y[2:0].
- The line is `{even, odd}`, 16 bits. The pixel is `line[{7−col,1'b0} +: 2]`, where col = hflip ? 7−x[2:0] : x[2:0].
- Channel output: `r = pix & {2{colour[2]}}`, and likewise g from colour[1] and b from colour[0].
- When `pixel_valid_out` is 0, `r`, `g` and `b` are forced to 0.

## Timing
Pipeline:
- Edge 1 registers NTBL read data together with the delayed `x[2:0]`, `y[2:0]` and valid.
- Edge 2 registers the PMB line and the delayed colour select, col and valid.
- Edge 3 registers `r`, `g`, `b` and `pixel_valid_out`.
- Latency is exactly 3 cycles, with one pixel per cycle and no stalls.

RAM ports:
- Read-first: a read and a write to the same address in the same cycle returns the old data.
- The new data is visible to reads issued on the next cycle.

Boundary conditions:
- A shadow write and frame start in the same cycle: this frame uses the old pend value, and the new value applies from the next frame.
- Reset:
  - Asserted: `r`, `g`, `b`, `pixel_valid_out`, all pipeline valids, `colors`, all `_pend` and all `_act` registers go to 0.
  - RAM contents are not reset.
  - Assertion mid-line empties the pipeline immediately.
  - Output resumes 3 cycles after the first valid input following deassertion.
- Parameter overlap of the PMB and NTBL windows is an elaboration-time error. `PMB_BANKS`>1 therefore requires a non-default `NTBL_BASE`.

## Configuration
Macro: `GPU_BG_SCROLL_EN`.
- Defined: scroll shadow registers, frame latch and Y-wrap logic are present.
- Undefined:
  - `eff_x = current_x` and `eff_y = current_y`.
  - Writes to offsets 961/962 reach RAM only.
  - Bank latching and `colors` behave identically in both builds.

## Structure
- Package `gpu_bg_pkg`:
  - tile-attribute packed struct;
  - shadow-register offsets (960–963);
  - `BG_LATENCY`=3;
  - `BG_SCREEN_H`=240.
- Sub-module `bg_byte_ram`:
  - simple dual-port, one write port and one registered read port, read-first;
  - parametrised depth;
  - instantiated three times: NTBL, PMB-even and PMB-odd.

## Test plan
- Reset: with `rst_n`=0 mid-line → all outputs 0. After release, a valid pixel appears exactly 3 cycles after the first `pixel_valid_in`=1.
- Basic render: NTBL[0]=8'h01, NTBL[960]=8'h2C (colour0=4, colour1=5), PMB pattern1 row0 = 16'hE400. Sweep (0..3,0) → r = 3, 2, 1, 0; g = b = 0.
- Flips: tile byte 8'hE1 with the same pattern → pixel (7,7) reads pattern (0,0) = 3. Colour1 = 5 gives r = b = 3.
- Scroll wrap: scroll_x=250, scroll_y=236 latched. Pixel (10,10) fetches eff (4,6); pixel (0,4) fetches eff_y=0.
- Frame latch: write scroll_x=8 mid-frame → no change until the next (0,0). A write coincident with (0,0) applies one frame later.
- Write gating and collision: a write with `writable`=0 leaves the old tile rendered. A write with `writable`=1 to the address being read returns old data that cycle and new data the next.
